// File: rtl/store_lane_merge.sv
// Store lane merger: narrows a register value to byte/half/word and writes it to data memory,
// using read-modify-write for sub-word stores. Optional macro STORE_LINE_FWD_EN adds a one-entry written-word buffer.
module store_lane_merge #(
  parameter int MEM_AW     = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  output logic              done,
  output logic              misaligned_err
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE, ERR} state_t;

  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

  state_t            state, stateNext;
  logic [MEM_AW-1:0] wordAddrQ;
  logic [1:0]        laneQ;
  logic [1:0]        sizeQ;
  logic [31:0]       dataQ;
  logic [31:0]       baseQ;
  logic [1:0]        waitCnt;
  logic [31:0]       merged;
  logic              accept;
  logic              misaligned;
  logic              fwdHit;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^req_addr[31:MEM_AW+2];
  assign accept         = (state == IDLE) && req_valid;
  assign misaligned     = (req_size == 2'b11) ||
                          (req_size == 2'b01 && req_addr[0]) ||
                          (req_size == 2'b10 && req_addr[1:0] != 2'b00);

`ifdef STORE_LINE_FWD_EN
  logic              fwdValid;
  logic [MEM_AW-1:0] fwdAddr;
  logic [31:0]       fwdWord;

  assign fwdHit = fwdValid && (fwdAddr == req_addr[MEM_AW+1:2]);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      fwdValid <= 1'b0;
      fwdAddr  <= '0;
      fwdWord  <= '0;
    end else if (state == WR) begin
      fwdValid <= 1'b1;
      fwdAddr  <= wordAddrQ;
      fwdWord  <= merged;
    end
  end
`else
  assign fwdHit = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (req_valid) begin
        if (misaligned)                         stateNext = ERR;
        else if (req_size == 2'b10 || fwdHit)   stateNext = WR;
        else                                    stateNext = RD;
      end
      RD:      stateNext = WAIT;
      WAIT:    if (waitCnt == WAIT_LAST) stateNext = WR;
      WR:      stateNext = DONE;
      DONE:    stateNext = IDLE;
      ERR:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wordAddrQ <= '0;
      laneQ     <= '0;
      sizeQ     <= '0;
      dataQ     <= '0;
      waitCnt   <= '0;
    end else begin
      if (accept) begin
        wordAddrQ <= req_addr[MEM_AW+1:2];
        laneQ     <= req_addr[1:0];
        sizeQ     <= req_size;
        dataQ     <= req_data;
      end
      waitCnt <= (state == WAIT) ? waitCnt + 2'd1 : '0;
    end
  end

  // Base word for the merge: memory read on the last WAIT cycle, or the buffered word on a hit.
  always_ff @(posedge Clk) begin
    if (!Reset)
      baseQ <= '0;
    else if (state == WAIT && waitCnt == WAIT_LAST)
      baseQ <= mem_rd_data;
`ifdef STORE_LINE_FWD_EN
    else if (accept && fwdHit)
      baseQ <= fwdWord;
`endif
  end

  always_comb begin
    merged = baseQ;
    case (sizeQ)
      2'b00:   merged[{laneQ, 3'b000} +: 8]     = dataQ[7:0];
      2'b01:   merged[{laneQ[1], 4'b0000} +: 16] = dataQ[15:0];
      2'b10:   merged = dataQ;
      default: merged = baseQ;
    endcase
  end

  always_comb begin
    req_ready      = (state == IDLE);
    mem_rd_en      = (state == RD);
    mem_wr_en      = (state == WR);
    mem_wr_data    = (state == WR) ? merged : '0;
    mem_addr       = (state == RD || state == WAIT || state == WR) ? wordAddrQ : '0;
    done           = (state == DONE) || (state == ERR);
    misaligned_err = (state == ERR);
  end

endmodule

// File: tb/tb_store_lane_merge.sv
// Scoreboard bench for store_lane_merge: two instances (read latency 1 and 3) share one
// randomized store stream; a byte-lane reference memory predicts every write and latency.
module tb_store_lane_merge;

  typedef struct {
    bit          err;
    logic [9:0]  addr;
    logic [31:0] data;
    int          lat;
    int          rds;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        reqValid = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqData = '0;
  logic [1:0]  reqSize = '0;
  logic [1:0]  reqReady;
  logic [1:0]  memRdEn;
  logic [1:0]  memWrEn;
  logic [1:0]  doneW;
  logic [1:0]  misErr;
  logic [9:0]  memAddr [2];
  logic [31:0] memRdData [2];
  logic [31:0] memWrData [2];

  logic        plEn = 1'b0;
  logic [9:0]  plAddr = '0;
  logic [31:0] plData = '0;

  exp_t        expQ [2][$];
  logic [31:0] refMem [1024];
  bit          fwdV = 0;
  logic [9:0]  fwdA = '0;
  int          checks = 0;
  int          errors = 0;

  always #5 Clk = ~Clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gDut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] mem [1024];
    logic [31:0] rdPipe [4];
    int   cyc = 0;
    int   startCyc = 0;
    int   rdSeen = 0;
    bit   wrSeen = 0;
    exp_t e;

    store_lane_merge #(.MEM_AW(10), .RD_LATENCY(LAT)) dut (
      .Clk(Clk), .Reset(Reset),
      .req_valid(reqValid), .req_ready(reqReady[g]),
      .req_addr(reqAddr), .req_data(reqData), .req_size(reqSize),
      .mem_addr(memAddr[g]), .mem_rd_en(memRdEn[g]), .mem_rd_data(memRdData[g]),
      .mem_wr_en(memWrEn[g]), .mem_wr_data(memWrData[g]),
      .done(doneW[g]), .misaligned_err(misErr[g])
    );

    // Memory model: data is valid LAT cycles after the read strobe, garbage otherwise.
    always @(posedge Clk) begin
      if (plEn) mem[plAddr] <= plData;
      else if (memWrEn[g]) mem[memAddr[g]] <= memWrData[g];
      rdPipe[0] <= memRdEn[g] ? mem[memAddr[g]] : $urandom;
      for (int k = 1; k < 4; k++) rdPipe[k] <= rdPipe[k-1];
    end
    assign memRdData[g] = rdPipe[LAT-1];

    always @(negedge Clk) begin
      if (!Reset) begin
        expQ[g].delete();
        rdSeen = 0;
        wrSeen = 0;
      end else begin
        if (reqValid && reqReady[g]) begin
          startCyc = cyc;
          rdSeen = 0;
          wrSeen = 0;
        end
        if (memRdEn[g]) rdSeen++;
        if (memWrEn[g]) begin
          if (expQ[g].size() == 0) chk($sformatf("lat%0d unexpectedWrite", LAT), 32'(memWrEn[g]), 0);
          else begin
            chk($sformatf("lat%0d wrAddr", LAT), 32'(memAddr[g]), 32'(expQ[g][0].addr));
            chk($sformatf("lat%0d wrData", LAT), memWrData[g], expQ[g][0].data);
          end
          wrSeen = 1;
        end
        if (doneW[g]) begin
          if (expQ[g].size() == 0) chk($sformatf("lat%0d unexpectedDone", LAT), 32'(doneW[g]), 0);
          else begin
            e = expQ[g].pop_front();
            chk($sformatf("lat%0d misalignedErr", LAT), 32'(misErr[g]), 32'(e.err));
            chk($sformatf("lat%0d latency", LAT), 32'(cyc - startCyc), 32'(e.lat));
            chk($sformatf("lat%0d readCount", LAT), 32'(rdSeen), 32'(e.rds));
            chk($sformatf("lat%0d wroteMem", LAT), 32'(wrSeen), 32'(!e.err));
          end
        end else if (misErr[g]) begin
          chk($sformatf("lat%0d errWithoutDone", LAT), 32'(doneW[g]), 32'(misErr[g]));
        end
      end
      cyc++;
    end
  end

  task automatic checkIdle(input string nm);
    for (int unsigned g = 0; g < 2; g++)
      chk($sformatf("%s dut%0d", nm, g),
          {reqReady[g], memRdEn[g], memWrEn[g], doneW[g], misErr[g], 27'(memAddr[g])} | memWrData[g],
          32'h8000_0000);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s, input bit model);
    int   t = 0;
    int   lats [2] = '{1, 3};
    exp_t e;
    logic [9:0]  wa;
    logic [31:0] nw;
    bit          hit;
    while (!(reqReady[0] && reqReady[1]) && t < 64) begin
      @(posedge Clk); #1; t++;
    end
    chk("readyTimeout", 32'(t >= 64), 0);
    if (model) begin
      wa = a[11:2];
      e.err = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
      e.addr = wa;
`ifdef STORE_LINE_FWD_EN
      hit = fwdV && (fwdA == wa);
`else
      hit = 0;
`endif
      nw = refMem[wa];
      if (s == 2'b10) nw = d;
      else if (s == 2'b00) nw[8*a[1:0] +: 8] = d[7:0];
      else nw[16*a[1] +: 16] = d[15:0];
      e.data = nw;
      if (!e.err) begin
        refMem[wa] = nw;
        fwdV = 1;
        fwdA = wa;
      end
      for (int unsigned g = 0; g < 2; g++) begin
        e.lat = e.err ? 1 : (s == 2'b10 || hit) ? 2 : 3 + lats[g];
        e.rds = (!e.err && s != 2'b10 && !hit) ? 1 : 0;
        expQ[g].push_back(e);
      end
    end
    reqValid = 1; reqAddr = a; reqData = d; reqSize = s;
    @(posedge Clk); #1;
    reqValid = 0; reqAddr = $urandom; reqData = $urandom; reqSize = 2'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((expQ[0].size() != 0 || expQ[1].size() != 0) && t < 64) begin
      @(posedge Clk); #1; t++;
    end
    chk("drainTimeout", 32'(t >= 64), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    checkIdle("resetState");
    @(posedge Clk); #1;
    Reset = 1;

    for (int unsigned w = 0; w < 32; w++) begin
      refMem[w] = (w == 1) ? 32'hCAFEF00D : (w == 2) ? 32'h11223344 : (w == 4) ? 32'h0 : $urandom;
      plAddr = 10'(w); plData = refMem[w]; plEn = 1;
      @(posedge Clk); #1;
    end
    plEn = 0;

    issue(32'h0000_000A, 32'h0000_00AB, 2'b00, 1); drain();
    issue(32'h0000_0006, 32'h1234_5678, 2'b01, 1); drain();
    issue(32'h0000_0008, 32'hDEAD_BEEF, 2'b10, 1); drain();
    issue(32'h0000_0003, 32'h1111_1111, 2'b01, 1); drain();
    issue(32'h0000_0002, 32'h2222_2222, 2'b10, 1); drain();
    issue(32'h0000_0000, 32'h3333_3333, 2'b11, 1); drain();
    issue(32'h0000_0010, 32'h0000_0000, 2'b10, 1);
    issue(32'h0000_0011, 32'h0000_00FF, 2'b00, 1); drain();

    for (int unsigned i = 0; i < 200; i++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      issue(a, $urandom, 2'($urandom_range(0, 3)), 1);
    end
    drain();

    issue(32'h0000_00A1, 32'h0000_0055, 2'b00, 0);
    @(posedge Clk); #1;
    Reset = 0;
    fwdV = 0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1;
    @(negedge Clk);
    checkIdle("afterMidReset");
    repeat (6) @(posedge Clk);
    #1;

    for (int unsigned i = 0; i < 40; i++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      issue(a, $urandom, 2'($urandom_range(0, 2)), 1);
    end
    drain();

    repeat (2) @(posedge Clk);
    for (int unsigned w = 0; w < 32; w++) begin
      chk($sformatf("finalMem0[%0d]", w), gDut[0].mem[w], refMem[w]);
      chk($sformatf("finalMem1[%0d]", w), gDut[1].mem[w], refMem[w]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
